demod_fanout_ctrl: RTL and testbench

//   Read controller for one FIFO shared by several consumers. Example: the demod FIFO feeding the

---
 rtl/fm_pipeline_pkg.sv | 12 +
 rtl/demod_fanout_ctrl_sat_counter.sv | 21 ++
 rtl/demod_fanout_ctrl.sv | 102 ++++++++++
 tb/tb_demod_fanout_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_pipeline_pkg.sv
// Shared types and defaults for the FM demod pipeline control blocks.
package fm_pipeline_pkg;

  typedef enum logic [1:0] {
    FO_IDLE,
    FO_FETCH,
    FO_BCAST
  } fanout_state_t;

  localparam int FO_DEFAULT_CONSUMERS = 3;

endpackage : fm_pipeline_pkg

// File: rtl/demod_fanout_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; async active-high reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule : sat_counter

// File: rtl/demod_fanout_ctrl.sv
// Fan-out read controller: pops one FIFO word and holds it until every enabled consumer has taken it.
// Define FANOUT_STATS_EN to build the words_out / stall_cnt saturating statistics counters.
module demod_fanout_ctrl
  import fm_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_CONSUMERS = FO_DEFAULT_CONSUMERS,
  parameter int STAT_WIDTH    = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [DATA_WIDTH-1:0]               fifo_dout,
  input  logic                                fifo_empty,
  output logic                                fifo_rd_en,
  input  logic [NUM_CONSUMERS-1:0]            cons_enable,
  output logic [DATA_WIDTH-1:0]               cons_data,
  output logic [NUM_CONSUMERS-1:0]            cons_valid,
  input  logic [NUM_CONSUMERS-1:0]            cons_rd_en,
  output logic [STAT_WIDTH-1:0]               words_out,
  output logic [NUM_CONSUMERS*STAT_WIDTH-1:0] stall_cnt
);

  fanout_state_t              state_reg;
  logic [NUM_CONSUMERS-1:0]   pending_reg;
  logic [NUM_CONSUMERS-1:0]   pending_next;
  logic [DATA_WIDTH-1:0]      data_reg;
  logic                       done;

  always_comb begin
    pending_next = pending_reg & ~cons_rd_en & cons_enable;
    done         = (state_reg == FO_BCAST) && (pending_next == '0);
  end

  // The pop strobe is decoded from the current state and this cycle's accepts so the
  // next word can be requested in the same cycle the last consumer takes the current one.
  assign fifo_rd_en = !reset && !fifo_empty && ((state_reg == FO_IDLE) || done);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= FO_IDLE;
      pending_reg <= '0;
      data_reg    <= '0;
    end else begin
      case (state_reg)
        FO_IDLE: begin
          if (fifo_rd_en) begin
            state_reg <= FO_FETCH;
          end
        end
        FO_FETCH: begin
          data_reg    <= fifo_dout;
          pending_reg <= cons_enable;
          state_reg   <= (cons_enable == '0) ? FO_IDLE : FO_BCAST;
        end
        FO_BCAST: begin
          pending_reg <= pending_next;
          if (done) begin
            state_reg <= fifo_rd_en ? FO_FETCH : FO_IDLE;
          end
        end
        default: begin
          state_reg   <= FO_IDLE;
          pending_reg <= '0;
        end
      endcase
    end
  end

  // pending is only non-zero in BCAST, so it doubles as the per-consumer valid.
  assign cons_valid = pending_reg;
  assign cons_data  = data_reg;

`ifdef FANOUT_STATS_EN
  logic [NUM_CONSUMERS-1:0] stall_inc;

  sat_counter #(
    .WIDTH (STAT_WIDTH)
  ) u_words_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (done),
    .count (words_out)
  );

  for (genvar gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_stall
    assign stall_inc[gi] = (state_reg == FO_BCAST) && pending_reg[gi] && !cons_rd_en[gi];

    sat_counter #(
      .WIDTH (STAT_WIDTH)
    ) u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (stall_inc[gi]),
      .count (stall_cnt[gi*STAT_WIDTH +: STAT_WIDTH])
    );
  end
`else
  assign words_out = '0;
  assign stall_cnt = '0;
`endif

endmodule : demod_fanout_ctrl

// File: tb/tb_demod_fanout_ctrl.sv
// Randomised and directed bench for demod_fanout_ctrl against a word-level delivery model.
module tb_demod_fanout_ctrl;

  localparam int DW = 32;
  localparam int NC = 3;
  localparam int SW = 16;
  localparam int SAT = (1 << SW) - 1;
`ifdef FANOUT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [DW-1:0]     fifo_dout;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [NC-1:0]     cons_enable;
  logic [DW-1:0]     cons_data;
  logic [NC-1:0]     cons_valid;
  logic [NC-1:0]     cons_rd_en;
  logic [SW-1:0]     words_out;
  logic [NC*SW-1:0]  stall_cnt;

  demod_fanout_ctrl #(
    .DATA_WIDTH    (DW),
    .NUM_CONSUMERS (NC),
    .STAT_WIDTH    (SW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .fifo_dout   (fifo_dout),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .cons_enable (cons_enable),
    .cons_data   (cons_data),
    .cons_valid  (cons_valid),
    .cons_rd_en  (cons_rd_en),
    .words_out   (words_out),
    .stall_cnt   (stall_cnt)
  );

  always #5 clock = ~clock;

  // FIFO contents seen by the DUT, and an independent copy consumed by the model
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] model_q[$];

  // Word-level model: a word popped last cycle lands this cycle; a shown word is owed
  // to a set of consumers and retires once nobody enabled still owes an accept.
  bit            m_inflight;
  logic [DW-1:0] m_inflight_word;
  bit            m_shown;
  logic [NC-1:0] m_owed;
  logic [DW-1:0] m_data;
  int            m_words;
  int            m_stall[NC];
  int            n_xfer;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_inflight = 1'b0;
    m_inflight_word = '0;
    m_shown = 1'b0;
    m_owed = '0;
    m_data = '0;
    m_words = 0;
    for (int i = 0; i < NC; i++) m_stall[i] = 0;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    model_q.push_back(w);
  endtask

  task automatic check_outputs();
    chk("cons_valid", 64'(cons_valid), 64'(m_shown ? m_owed : '0));
    chk("cons_data", 64'(cons_data), 64'(m_data));
    chk("words_out", 64'(words_out), STATS ? 64'(m_words) : 64'd0);
    for (int i = 0; i < NC; i++)
      chk($sformatf("stall_cnt%0d", i), 64'(stall_cnt[i*SW +: SW]),
          STATS ? 64'(m_stall[i]) : 64'd0);
  endtask

  // One clock: check registered outputs, apply inputs, check the pop strobe, advance model.
  task automatic run_cycle(input logic [NC-1:0] en, input logic [NC-1:0] rd);
    bit rel, exp_rd, do_pop, fetch_now;
    check_outputs();
    cons_enable = en;
    cons_rd_en  = rd;
    fifo_empty  = (fifo_q.size() == 0);
    #1;
    rel    = m_shown && ((m_owed & ~rd & en) == '0);
    exp_rd = !reset && (model_q.size() != 0) && ((!m_shown && !m_inflight) || rel);
    chk("fifo_rd_en", 64'(fifo_rd_en), 64'(exp_rd));
    if (fifo_empty) chk("rd_while_empty", 64'(fifo_rd_en), 64'd0);
    do_pop = fifo_rd_en;
    if (!reset) begin
      fetch_now = m_inflight;
      if (m_shown) begin
        for (int i = 0; i < NC; i++)
          if (m_owed[i] && !rd[i] && m_stall[i] < SAT) m_stall[i]++;
        m_owed = m_owed & ~rd & en;
        if (rel) begin
          if (m_words < SAT) m_words++;
          m_shown = 1'b0;
          n_xfer++;
          $display("xfer %0d: word %08h delivered at %0t", n_xfer, m_data, $time);
        end
      end
      if (fetch_now) begin
        m_data = m_inflight_word;
        m_inflight = 1'b0;
        if (en != '0) begin
          m_shown = 1'b1;
          m_owed = en;
        end
      end
      if (exp_rd) begin
        m_inflight = 1'b1;
        m_inflight_word = model_q.pop_front();
      end
    end
    @(posedge clock);
    #1;
    if (do_pop && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
    @(negedge clock);
  endtask

  // Bounded wait for the model to present a word
  task automatic wait_shown(input logic [NC-1:0] en, input string tag);
    int n;
    n = 0;
    while (!m_shown && n < 20) begin
      run_cycle(en, '0);
      n++;
    end
    if (!m_shown) chk({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic drain(input int cycles);
    for (int k = 0; k < cycles; k++) run_cycle('1, '1);
  endtask

  initial begin
    logic [SW-1:0] w0;
    logic [NC-1:0] r_en;
    reset       = 1'b1;
    fifo_dout   = '0;
    fifo_empty  = 1'b1;
    cons_enable = '1;
    cons_rd_en  = '0;
    n_xfer      = 0;
    model_reset();

    // Reset with two words waiting: everything must stay quiet
    push(32'h11);
    push(32'h22);
    @(negedge clock);
    for (int k = 0; k < 3; k++) run_cycle(3'b111, 3'b000);
    reset = 1'b0;

    // First word appears two cycles after the pop; staggered accepts at 0, 3, 5
    wait_shown(3'b111, "first_word");
    chk("first_data", 64'(cons_data), 64'h11);
    for (int k = 0; k < 6; k++)
      run_cycle(3'b111, (k == 0) ? 3'b001 : (k == 3) ? 3'b010 : (k == 5) ? 3'b100 : 3'b000);
    wait_shown(3'b111, "second_word");
    chk("second_data", 64'(cons_data), 64'h22);
    drain(6);

    // Full-rate stream: 8 words in 16 cycles when everyone accepts at once
    w0 = words_out;
    for (int k = 0; k < 8; k++) push(32'hA000_0000 | 32'(k));
    for (int k = 0; k < 16; k++) run_cycle(3'b111, 3'b111);
    chk("burst_words", 64'(words_out - w0), STATS ? 64'd8 : 64'd0);
    chk("burst_drained", 64'(fifo_q.size()), 64'd0);
    drain(4);

    // Consumer 1 disabled and silent: flow continues for 0 and 2
    for (int k = 0; k < 6; k++) push($urandom);
    for (int k = 0; k < 40; k++)
      run_cycle(3'b101, 3'($urandom_range(0, 7)) & 3'b101);
    drain(6);

    // Consumer 2 released by dropping its enable mid-broadcast
    push(32'h5555_AAAA);
    wait_shown(3'b111, "enable_drop");
    run_cycle(3'b111, 3'b011);
    run_cycle(3'b011, 3'b000);
    chk("released_valid", 64'(cons_valid), 64'd0);
    drain(4);

    // Reset while holding 0x33: the held word is lost, 0x44 comes next
    push(32'h33);
    push(32'h44);
    wait_shown(3'b111, "hold_33");
    run_cycle(3'b111, 3'b000);
    reset = 1'b1;
    #1;
    chk("reset_valid_now", 64'(cons_valid), 64'd0);
    model_reset();
    @(negedge clock);
    run_cycle(3'b111, 3'b000);
    reset = 1'b0;
    wait_shown(3'b111, "after_reset");
    chk("post_reset_data", 64'(cons_data), 64'h44);
    drain(6);

`ifdef FANOUT_STATS_EN
    // Long stall on consumer 0 must saturate its counter
    push(32'h66);
    wait_shown(3'b001, "stall_word");
    for (int k = 0; k < 70000; k++) run_cycle(3'b001, 3'b000);
    chk("stall_sat", 64'(stall_cnt[SW-1:0]), 64'hFFFF);
    drain(4);
`endif

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8) push($urandom);
      r_en = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      run_cycle(r_en, 3'($urandom_range(0, 7)));
    end
    drain(20);
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_demod_fanout_ctrl
